// File: rtl/seq_pkg.sv
// seq_pkg: opcode constants, FSM state encoding and op classification helpers for datapath_sequencer
package seq_pkg;
  typedef logic [2:0] op_t;
  localparam op_t OP_NOP   = 3'd0;
  localparam op_t OP_LDA   = 3'd1;
  localparam op_t OP_ADDA  = 3'd2;
  localparam op_t OP_ADDB  = 3'd3;
  localparam op_t OP_MOVBA = 3'd4;
  typedef enum logic [1:0] {IDLE, T1, T2, DONE} state_t;
  function automatic logic needs_t2(op_t op);
    return op == OP_ADDA || op == OP_ADDB || op == OP_MOVBA;
  endfunction
  function automatic logic is_legal(op_t op);
    return op <= OP_MOVBA;
  endfunction
endpackage

// File: rtl/datapath_sequencer_if.sv
// datapath_sequencer_if: micro-op request handshake plus RA/RB/RZ strobe and immediate buses
interface datapath_sequencer_if #(parameter int DATA_W = 32, parameter int OP_W = 3);
  logic              start;
  logic [OP_W-1:0]   opcode;
  logic [DATA_W-1:0] imm;
  logic              busy;
  logic              done;
  logic              error;
  logic              RAin;
  logic              RBin;
  logic              RZin;
  logic              RAout;
  logic              RBout;
  logic              RZout;
  logic [DATA_W-1:0] AddImmediate;
  logic [DATA_W-1:0] RegisterAImmediate;
  modport master (
    output start, opcode, imm,
    input  busy, done, error, RAin, RBin, RZin, RAout, RBout, RZout, AddImmediate, RegisterAImmediate
  );
  modport slave (
    input  start, opcode, imm,
    output busy, done, error, RAin, RBin, RZin, RAout, RBout, RZout, AddImmediate, RegisterAImmediate
  );
endinterface

// File: rtl/seq_decode.sv
// seq_decode: combinational map from FSM state and latched op/imm to datapath strobes and immediates
module seq_decode import seq_pkg::*; #(parameter int DATA_W = 32) (
  input  state_t            state,
  input  op_t               op,
  input  logic [DATA_W-1:0] imm,
  output logic              ra_in,
  output logic              rb_in,
  output logic              rz_in,
  output logic              ra_out,
  output logic              rb_out,
  output logic              rz_out,
  output logic [DATA_W-1:0] add_imm,
  output logic [DATA_W-1:0] reg_a_imm
);
  logic t1, t2;
  assign t1 = state == T1;
  assign t2 = state == T2;
  assign ra_in  = (t1 && op == OP_LDA) || (t2 && (op == OP_ADDA || op == OP_MOVBA));
  assign rb_in  = t2 && op == OP_ADDB;
  assign rz_in  = t1 && needs_t2(op);
  assign ra_out = t1 && (op == OP_ADDA || op == OP_ADDB);
  assign rb_out = t1 && op == OP_MOVBA;
  assign rz_out = t2;
  // MOVBA passes RB through the adder, so its immediate stays zero
  assign add_imm   = ra_out ? imm : '0;
  assign reg_a_imm = (t1 && op == OP_LDA) ? imm : '0;
endmodule

// File: rtl/datapath_sequencer.sv
// datapath_sequencer: expands micro-ops into T-state strobe sequences; SEQ_PERF_COUNT_EN adds op_count
module datapath_sequencer import seq_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 3
) (
  input logic clock,
  input logic clear,
  datapath_sequencer_if.slave bus
`ifdef SEQ_PERF_COUNT_EN
  ,
  output logic [15:0] op_count
`endif
);
  state_t            state_q, state_d;
  op_t               op_q, op_d, op_in;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic              accept;
  assign op_in  = op_t'(bus.opcode);
  assign accept = state_q == IDLE && bus.start;
  always_comb begin
    op_d    = accept ? op_in : op_q;
    imm_d   = accept ? bus.imm : imm_q;
    state_d = state_q == IDLE ? (bus.start ? ((op_in == OP_NOP || !is_legal(op_in)) ? DONE : T1) : IDLE)
            : state_q == T1   ? (needs_t2(op_q) ? T2 : DONE)
            : state_q == T2   ? DONE
            : IDLE;
  end
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= IDLE;
      op_q    <= '0;
      imm_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      imm_q   <= imm_d;
    end
  end
  assign bus.busy  = state_q != IDLE;
  assign bus.done  = state_q == DONE;
  assign bus.error = state_q == DONE && !is_legal(op_q);
  seq_decode #(.DATA_W(DATA_W)) u_decode (
    .state     (state_q),
    .op        (op_q),
    .imm       (imm_q),
    .ra_in     (bus.RAin),
    .rb_in     (bus.RBin),
    .rz_in     (bus.RZin),
    .ra_out    (bus.RAout),
    .rb_out    (bus.RBout),
    .rz_out    (bus.RZout),
    .add_imm   (bus.AddImmediate),
    .reg_a_imm (bus.RegisterAImmediate)
  );
`ifdef SEQ_PERF_COUNT_EN
  logic [15:0] op_count_q, op_count_d;
  always_comb op_count_d = (state_q == DONE && op_count_q != 16'hFFFF) ? op_count_q + 16'd1 : op_count_q;
  always_ff @(posedge clock) begin
    if (clear) op_count_q <= '0;
    else op_count_q <= op_count_d;
  end
  assign op_count = op_count_q;
`endif
endmodule

// File: tb/tb_datapath_sequencer.sv
// tb_datapath_sequencer: directed self-checking bench with an RA/RB/RZ datapath model
module tb_datapath_sequencer;
  logic clock = 0;
  logic clear = 1;
  int n_checks = 0;
  int n_fail = 0;
  datapath_sequencer_if #(.DATA_W(32), .OP_W(3)) bus_if ();
`ifdef SEQ_PERF_COUNT_EN
  logic [15:0] op_count;
`endif
  datapath_sequencer #(.DATA_W(32), .OP_W(3)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus_if.slave)
`ifdef SEQ_PERF_COUNT_EN
    ,
    .op_count (op_count)
`endif
  );
  always #5 clock = ~clock;
  // {RAin,RBin,RZin,RAout,RBout,RZout,busy,done,error}
  logic [8:0] ctl;
  assign ctl = {bus_if.RAin, bus_if.RBin, bus_if.RZin, bus_if.RAout, bus_if.RBout, bus_if.RZout,
                bus_if.busy, bus_if.done, bus_if.error};
  logic [31:0] ra = 0, rb = 0, rz = 0;
  always @(posedge clock) begin
    logic [31:0] b;
    b = bus_if.RAout ? ra : bus_if.RBout ? rb : bus_if.RZout ? rz : 32'h0;
    if (bus_if.RZin) rz <= b + bus_if.AddImmediate;
    if (bus_if.RAin) ra <= bus_if.RZout ? b : bus_if.RegisterAImmediate;
    if (bus_if.RBin) rb <= b;
  end
  always @(negedge clock) begin
    n_checks++;
    if (32'($countones({bus_if.RAout, bus_if.RBout, bus_if.RZout})) > 1) begin
      n_fail++;
      $display("FAIL bus_out_onehot t=%0t got RAout/RBout/RZout=%b want at most one", $time,
               {bus_if.RAout, bus_if.RBout, bus_if.RZout});
    end
    n_checks++;
    if ((!bus_if.busy || bus_if.done) && (bus_if.RAin || bus_if.RBin || bus_if.RZin)) begin
      n_fail++;
      $display("FAIL in_strobe_idle t=%0t got RAin/RBin/RZin=%b want 000", $time,
               {bus_if.RAin, bus_if.RBin, bus_if.RZin});
    end
  end
  task automatic issue(input logic [2:0] op, input logic [31:0] v);
    @(negedge clock);
    bus_if.start = 1;
    bus_if.opcode = op;
    bus_if.imm = v;
    @(negedge clock);
    bus_if.start = 0;
    bus_if.opcode = 0;
    bus_if.imm = 0;
  endtask
  task automatic test_reset;
    repeat (2) @(negedge clock);
    n_checks++;
    if (ctl !== 9'b0 || bus_if.AddImmediate !== 0 || bus_if.RegisterAImmediate !== 0) begin
      n_fail++;
      $display("FAIL reset got ctl=%b add=%h rega=%h want 0", ctl, bus_if.AddImmediate, bus_if.RegisterAImmediate);
    end
    clear = 0;
  endtask
  task automatic test_lda;
    issue(3'd1, 32'h5);
    n_checks++;
    if (ctl !== 9'b100_000_100 || bus_if.RegisterAImmediate !== 32'h5 || bus_if.AddImmediate !== 0) begin
      n_fail++;
      $display("FAIL lda_t1 got ctl=%b rega=%h add=%h want 100000100 5 0", ctl, bus_if.RegisterAImmediate, bus_if.AddImmediate);
    end
    @(negedge clock);
    n_checks++;
    if (ctl !== 9'b000_000_110 || bus_if.RegisterAImmediate !== 0) begin
      n_fail++;
      $display("FAIL lda_done got ctl=%b rega=%h want 000000110 0", ctl, bus_if.RegisterAImmediate);
    end
    @(negedge clock);
    n_checks++;
    if (ctl !== 9'b0 || ra !== 32'h5) begin
      n_fail++;
      $display("FAIL lda_idle got ctl=%b ra=%h want 0 5", ctl, ra);
    end
  endtask
  task automatic test_addb;
    issue(3'd3, 32'h5);
    n_checks++;
    if (ctl !== 9'b001_100_100 || bus_if.AddImmediate !== 32'h5 || bus_if.RegisterAImmediate !== 0) begin
      n_fail++;
      $display("FAIL addb_t1 got ctl=%b add=%h rega=%h want 001100100 5 0", ctl, bus_if.AddImmediate, bus_if.RegisterAImmediate);
    end
    @(negedge clock);
    n_checks++;
    if (ctl !== 9'b010_001_100 || bus_if.AddImmediate !== 0) begin
      n_fail++;
      $display("FAIL addb_t2 got ctl=%b add=%h want 010001100 0", ctl, bus_if.AddImmediate);
    end
    @(negedge clock);
    n_checks++;
    if (ctl !== 9'b000_000_110 || rb !== 32'd10) begin
      n_fail++;
      $display("FAIL addb_done got ctl=%b rb=%h want 000000110 a", ctl, rb);
    end
    @(negedge clock);
  endtask
  task automatic test_adda_wrap;
    issue(3'd1, 32'h1);
    repeat (2) @(negedge clock);
    issue(3'd2, 32'hFFFF_FFFF);
    n_checks++;
    if (ctl !== 9'b001_100_100 || bus_if.AddImmediate !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL adda_t1 got ctl=%b add=%h want 001100100 ffffffff", ctl, bus_if.AddImmediate);
    end
    @(negedge clock);
    n_checks++;
    if (ctl !== 9'b100_001_100 || bus_if.AddImmediate !== 0 || bus_if.RegisterAImmediate !== 0) begin
      n_fail++;
      $display("FAIL adda_t2 got ctl=%b add=%h rega=%h want 100001100 0 0", ctl, bus_if.AddImmediate, bus_if.RegisterAImmediate);
    end
    @(negedge clock);
    n_checks++;
    if (ctl !== 9'b000_000_110 || ra !== 32'h0) begin
      n_fail++;
      $display("FAIL adda_wrap got ctl=%b ra=%h want 000000110 0", ctl, ra);
    end
    @(negedge clock);
  endtask
  task automatic test_movba;
    issue(3'd4, 32'h123);
    n_checks++;
    if (ctl !== 9'b001_010_100 || bus_if.AddImmediate !== 0) begin
      n_fail++;
      $display("FAIL movba_t1 got ctl=%b add=%h want 001010100 0", ctl, bus_if.AddImmediate);
    end
    @(negedge clock);
    n_checks++;
    if (ctl !== 9'b100_001_100) begin
      n_fail++;
      $display("FAIL movba_t2 got ctl=%b want 100001100", ctl);
    end
    @(negedge clock);
    n_checks++;
    if (ctl !== 9'b000_000_110 || ra !== 32'd10) begin
      n_fail++;
      $display("FAIL movba_done got ctl=%b ra=%h want 000000110 a", ctl, ra);
    end
    @(negedge clock);
  endtask
  task automatic test_nop_illegal;
    issue(3'd0, 32'h7);
    n_checks++;
    if (ctl !== 9'b000_000_110) begin
      n_fail++;
      $display("FAIL nop_done got ctl=%b want 000000110", ctl);
    end
    @(negedge clock);
    n_checks++;
    if (ctl !== 9'b0) begin
      n_fail++;
      $display("FAIL nop_idle got ctl=%b want 0", ctl);
    end
    issue(3'd6, 32'h9);
    n_checks++;
    if (ctl !== 9'b000_000_111 || bus_if.AddImmediate !== 0 || bus_if.RegisterAImmediate !== 0) begin
      n_fail++;
      $display("FAIL illegal_done got ctl=%b add=%h rega=%h want 000000111 0 0", ctl, bus_if.AddImmediate, bus_if.RegisterAImmediate);
    end
    @(negedge clock);
    n_checks++;
    if (ctl !== 9'b0) begin
      n_fail++;
      $display("FAIL illegal_idle got ctl=%b want 0", ctl);
    end
  endtask
  task automatic test_back_to_back;
    @(negedge clock);
    bus_if.start = 1;
    bus_if.opcode = 3'd1;
    bus_if.imm = 32'h77;
    @(negedge clock);
    n_checks++;
    if (ctl !== 9'b100_000_100) begin
      n_fail++;
      $display("FAIL held_t1 got ctl=%b want 100000100", ctl);
    end
    @(negedge clock);
    n_checks++;
    if (ctl !== 9'b000_000_110) begin
      n_fail++;
      $display("FAIL held_done got ctl=%b want 000000110", ctl);
    end
    @(negedge clock);
    n_checks++;
    if (ctl !== 9'b0) begin
      n_fail++;
      $display("FAIL held_idle got ctl=%b want 0", ctl);
    end
    @(negedge clock);
    bus_if.start = 0;
    n_checks++;
    if (ctl !== 9'b100_000_100 || bus_if.RegisterAImmediate !== 32'h77) begin
      n_fail++;
      $display("FAIL held_reaccept got ctl=%b rega=%h want 100000100 77", ctl, bus_if.RegisterAImmediate);
    end
    repeat (2) @(negedge clock);
  endtask
  task automatic test_clear_mid_op;
    issue(3'd2, 32'h3);
    n_checks++;
    if (ctl !== 9'b001_100_100) begin
      n_fail++;
      $display("FAIL clr_t1 got ctl=%b want 001100100", ctl);
    end
    clear = 1;
    @(negedge clock);
    n_checks++;
    if (ctl !== 9'b0 || bus_if.AddImmediate !== 0) begin
      n_fail++;
      $display("FAIL clr_abort got ctl=%b add=%h want 0 0", ctl, bus_if.AddImmediate);
    end
    @(negedge clock);
    clear = 0;
    @(negedge clock);
    n_checks++;
    if (ctl !== 9'b0) begin
      n_fail++;
      $display("FAIL clr_nodone got ctl=%b want 0", ctl);
    end
    issue(3'd1, 32'h42);
    n_checks++;
    if (ctl !== 9'b100_000_100 || bus_if.RegisterAImmediate !== 32'h42) begin
      n_fail++;
      $display("FAIL clr_lda_t1 got ctl=%b rega=%h want 100000100 42", ctl, bus_if.RegisterAImmediate);
    end
    @(negedge clock);
    n_checks++;
    if (ctl !== 9'b000_000_110 || ra !== 32'h42) begin
      n_fail++;
      $display("FAIL clr_lda_done got ctl=%b ra=%h want 000000110 42", ctl, ra);
    end
    @(negedge clock);
  endtask
`ifdef SEQ_PERF_COUNT_EN
  task automatic test_perf;
    n_checks++;
    if (op_count !== 16'd0) begin
      n_fail++;
      $display("FAIL perf_reset got %h want 0", op_count);
    end
    issue(3'd0, 0);
    issue(3'd7, 0);
    issue(3'd1, 32'h1);
    repeat (2) @(negedge clock);
    n_checks++;
    if (op_count !== 16'd3) begin
      n_fail++;
      $display("FAIL perf_count got %h want 3", op_count);
    end
    force dut.op_count_q = 16'hFFFE;
    @(negedge clock);
    release dut.op_count_q;
    repeat (3) issue(3'd0, 0);
    @(negedge clock);
    n_checks++;
    if (op_count !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL perf_sat got %h want ffff", op_count);
    end
  endtask
`endif
  initial begin
    bus_if.start = 0;
    bus_if.opcode = 0;
    bus_if.imm = 0;
    test_reset;
`ifdef SEQ_PERF_COUNT_EN
    test_perf;
`endif
    test_lda;
    test_addb;
    test_adda_wrap;
    test_movba;
    test_nop_illegal;
    test_back_to_back;
    test_clear_mid_op;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
